// File: rtl/lock_pkg.sv
// Shared types and helpers for the key-locked digit-serial adder.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, used to size the digit counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-wide ripple-carry adder built from full-adder cells: {co, s} = a + b + c.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             co_o
);

  logic [DIGIT:0] cy;

  always_comb begin
    cy  = '0;
    s_o = '0;
    cy[0] = c_i;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
      cy[i+1] = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = cy[DIGIT];
  end

endmodule

// File: rtl/locked_digit_serial_adder.sv
// Key-locked adder: sum = (a ^ key) + b + cin, computed DIGIT bits per cycle
// behind valid/ready handshakes on both sides.
module locked_digit_serial_adder
  import lock_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             cout
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = clog2(NDIG + 1);

  state_e           state_q;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] ea_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] dsum;
  logic             dco;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i  (ea_q[DIGIT-1:0]),
    .b_i  (b_q[DIGIT-1:0]),
    .c_i  (carry_q),
    .s_o  (dsum),
    .co_o (dco)
  );

  // cnt counts completed digits; the extra count value spends one cycle
  // publishing the result into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      ea_q        <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_load) key_q <= key_in;
          if (in_valid) begin
            ea_q       <= a ^ key_q;
            b_q        <= b;
            carry_q    <= cin;
            res_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (cnt_q != CW'(NDIG)) begin
            ea_q    <= ea_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            res_q   <= WIDTH'({dsum, res_q} >> DIGIT);
            carry_q <= dco;
            cnt_q   <= cnt_q + CW'(1);
          end else begin
            sum_q       <= {carry_q, res_q};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = sum_q[WIDTH];

endmodule

// File: tb/tb_locked_digit_serial_adder.sv
// Directed and randomised checks of the key-locked digit-serial adder
// (WIDTH=8 with DIGIT=2, plus a single-cycle DIGIT=8 instance).
module tb_locked_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       key_load, in_valid, cin, out_ready;
  logic [7:0] key_in, a, b;
  logic       in_ready, out_valid, cout;
  logic [8:0] sum;

  logic       d8_key_load, d8_in_valid, d8_cin, d8_out_ready;
  logic [7:0] d8_key_in, d8_a, d8_b;
  logic       d8_in_ready, d8_out_valid, d8_cout;
  logic [8:0] d8_sum;
  logic [7:0] d8_key;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  locked_digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  locked_digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .key_load(d8_key_load), .key_in(d8_key_in),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .a(d8_a), .b(d8_b), .cin(d8_cin),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready), .sum(d8_sum), .cout(d8_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k);
    key_load = 1'b1;
    key_in   = k;
    step();
    key_load = 1'b0;
  endtask

  // One full transaction on the DIGIT=2 instance, optionally loading a key on the accept cycle.
  task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                    input logic kl, input logic [7:0] kv, input logic [8:0] exp);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin step(); k++; end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = ci; in_valid = 1'b1; key_load = kl; key_in = kv;
    step();
    in_valid = 1'b0; key_load = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin step(); k++; end
    check({tag, "_lat"}, 32'(k), 32'd5);
    check({tag, "_sum"}, 32'(sum), 32'(exp));
    check({tag, "_cout"}, 32'(cout), 32'(exp[8]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdyback"}, 32'(in_ready), 32'd1);
  endtask

  // One transaction on the DIGIT=8 instance against the bench's key model.
  task automatic d8_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic kl, input logic [7:0] kv, input int bp);
    int k;
    logic [8:0] exp;
    k = 0;
    while (!d8_in_ready && k < 20) begin step(); k++; end
    check("d8_rdy", 32'(d8_in_ready), 32'd1);
    exp = 9'(av ^ d8_key) + 9'(bv) + 9'(ci);
    if (kl) d8_key = kv;
    d8_a = av; d8_b = bv; d8_cin = ci; d8_in_valid = 1'b1; d8_key_load = kl; d8_key_in = kv;
    step();
    d8_in_valid = 1'b0; d8_key_load = 1'b0;
    k = 0;
    while (!d8_out_valid && k < 20) begin step(); k++; end
    check("d8_lat", 32'(k), 32'd2);
    repeat (bp) step();
    check("d8_sum", 32'(d8_sum), 32'(exp));
    d8_out_ready = 1'b1;
    step();
    d8_out_ready = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    key_load = 0; key_in = 0; in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
    d8_key_load = 0; d8_key_in = 0; d8_in_valid = 0; d8_a = 0; d8_b = 0; d8_cin = 0;
    d8_out_ready = 0; d8_key = 8'h00;
    step(); step();
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_irdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    load_key(8'h02);
    op("t1", 8'h02, 8'h02, 1'b0, 1'b0, 8'h00, 9'h002);
    load_key(8'h00);
    op("t2", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 9'h100);
    load_key(8'hFF);
    op("t3a", 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 9'h100);
    op("t3b", 8'h01, 8'h01, 1'b0, 1'b1, 8'h0F, 9'h0FF);
    op("t3c", 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 9'h00E);

    // Backpressure in DONE plus a key load attempted during RUN.
    a = 8'h10; b = 8'h20; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    key_load = 1'b1; key_in = 8'hAA;
    step();
    key_load = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin step(); k++; end
    check("t4_lat", 32'(k), 32'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'h55; b = 8'h66;
      step();
      check("t4_hold_sum", 32'(sum), 32'h040);
      check("t4_hold_ovalid", 32'(out_valid), 32'd1);
      check("t4_hold_irdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_vdrop", 32'(out_valid), 32'd0);
    op("t4_key", 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 9'h00E);

    // Reset in the middle of RUN.
    a = 8'h05; b = 8'h06; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    check("t5_ovalid", 32'(out_valid), 32'd0);
    check("t5_irdy", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    op("t5_after", 8'h03, 8'h04, 1'b0, 1'b0, 8'h00, 9'h007);

    d8_key = 8'h00;
    d8_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) begin
        d8_key_load = 1'b1;
        d8_key_in   = 8'($urandom);
        d8_key      = d8_key_in;
        step();
        d8_key_load = 1'b0;
      end
      d8_op(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(4) == 0),
            8'($urandom), int'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
